// File: rtl/execute_stage_if.sv
// Decode-to-execute bus: id_* payload driven by decode, ex_* results returned to EX/MEM and hazard logic.
interface execute_stage_if;
    logic        id_valid;
    logic [2:0]  id_alu_control;
    logic        id_alu_src;
    logic        id_reg_write;
    logic        id_mem_write;
    logic        id_jump;
    logic        id_branch;
    logic [1:0]  id_result_src;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [31:0] id_imm_ext;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;

    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic [1:0]  ex_result_src;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_write_data;
    logic [31:0] ex_pc_target;
    logic [31:0] ex_pc_plus4;
    logic        ex_zero;
    logic        ex_pc_src;

    modport master (
        output id_valid, id_alu_control, id_alu_src, id_reg_write, id_mem_write,
               id_jump, id_branch, id_result_src, id_rd1, id_rd2, id_imm_ext,
               id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd,
        input  ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_rd, ex_rs1,
               ex_rs2, ex_alu_result, ex_write_data, ex_pc_target, ex_pc_plus4,
               ex_zero, ex_pc_src
    );

    modport slave (
        input  id_valid, id_alu_control, id_alu_src, id_reg_write, id_mem_write,
               id_jump, id_branch, id_result_src, id_rd1, id_rd2, id_imm_ext,
               id_pc, id_pc_plus4, id_rs1, id_rs2, id_rd,
        output ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_rd, ex_rs1,
               ex_rs2, ex_alu_result, ex_write_data, ex_pc_target, ex_pc_plus4,
               ex_zero, ex_pc_src
    );
endinterface

// File: rtl/execute_stage.sv
// RISC-V execute stage: ID/EX register, operand forwarding, ALU, branch target and resolution.
module execute_stage (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic [1:0]            forward_a,
    input  logic [1:0]            forward_b,
    input  logic [31:0]           wb_result,
    input  logic [31:0]           mem_alu_result,
    execute_stage_if.slave        bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;

    typedef struct packed {
        logic            valid;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [1:0]      result_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [AW-1:0]   rs1;
        logic [AW-1:0]   rs2;
        logic [AW-1:0]   rd;
    } idex_t;

    idex_t           idex_d;
    idex_t           idex_q;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] alu_result;

    always_comb begin
        idex_d             = '0;
        idex_d.valid       = bus.id_valid;
        idex_d.alu_control = bus.id_alu_control;
        idex_d.alu_src     = bus.id_alu_src;
        idex_d.reg_write   = bus.id_reg_write;
        idex_d.mem_write   = bus.id_mem_write;
        idex_d.jump        = bus.id_jump;
        idex_d.branch      = bus.id_branch;
        idex_d.result_src  = bus.id_result_src;
        idex_d.rd1         = bus.id_rd1;
        idex_d.rd2         = bus.id_rd2;
        idex_d.imm_ext     = bus.id_imm_ext;
        idex_d.pc          = bus.id_pc;
        idex_d.pc_plus4    = bus.id_pc_plus4;
        idex_d.rs1         = bus.id_rs1;
        idex_d.rs2         = bus.id_rs2;
        idex_d.rd          = bus.id_rd;
    end

    // Flush beats stall so a squashed instruction never lingers in EX.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            idex_q <= '0;
        end else if (!stall_e) begin
            idex_q <= idex_d;
        end
    end

    always_comb begin
        src_a      = idex_q.rd1;
        write_data = idex_q.rd2;
        case (forward_a)
            2'b01:   src_a = wb_result;
            2'b10:   src_a = mem_alu_result;
            default: src_a = idex_q.rd1;
        endcase
        case (forward_b)
            2'b01:   write_data = wb_result;
            2'b10:   write_data = mem_alu_result;
            default: write_data = idex_q.rd2;
        endcase
        src_b = idex_q.alu_src ? idex_q.imm_ext : write_data;
    end

    always_comb begin
        alu_result = '0;
        case (idex_q.alu_control)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = XLEN'(($signed(src_a) < $signed(src_b)) ? 1 : 0);
            3'b110:  alu_result = src_a ^ src_b;
            default: alu_result = '0;
        endcase
    end

    assign bus.ex_valid      = idex_q.valid;
    assign bus.ex_reg_write  = idex_q.valid & idex_q.reg_write;
    assign bus.ex_mem_write  = idex_q.valid & idex_q.mem_write;
    assign bus.ex_result_src = idex_q.result_src;
    assign bus.ex_rd         = idex_q.rd;
    assign bus.ex_rs1        = idex_q.rs1;
    assign bus.ex_rs2        = idex_q.rs2;
    assign bus.ex_alu_result = alu_result;
    assign bus.ex_write_data = write_data;
    assign bus.ex_pc_target  = idex_q.pc + idex_q.imm_ext;
    assign bus.ex_pc_plus4   = idex_q.pc_plus4;
    assign bus.ex_zero       = (alu_result == '0);
    // Only beq is resolved here; jumps redirect unconditionally.
    assign bus.ex_pc_src     = idex_q.valid & (idex_q.jump | (idex_q.branch & (alu_result == '0)));
endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage: ALU/forwarding vector table plus pipeline-control sequences.
module tb_execute_stage;
    logic        clk;
    logic        reset;
    logic        stall_e;
    logic        flush_e;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] wb_result;
    logic [31:0] mem_alu_result;

    execute_stage_if bus ();

    execute_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_e        (stall_e),
        .flush_e        (flush_e),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .wb_result      (wb_result),
        .mem_alu_result (mem_alu_result),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic [2:0]  ctl;
        logic        src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] wb;
        logic [31:0] mem;
        logic [31:0] exp_res;
        logic [31:0] exp_wd;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic clear_id();
        bus.id_valid       = 1'b0;
        bus.id_alu_control = 3'b000;
        bus.id_alu_src     = 1'b0;
        bus.id_reg_write   = 1'b0;
        bus.id_mem_write   = 1'b0;
        bus.id_jump        = 1'b0;
        bus.id_branch      = 1'b0;
        bus.id_result_src  = 2'b00;
        bus.id_rd1         = '0;
        bus.id_rd2         = '0;
        bus.id_imm_ext     = '0;
        bus.id_pc          = '0;
        bus.id_pc_plus4    = '0;
        bus.id_rs1         = '0;
        bus.id_rs2         = '0;
        bus.id_rd          = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks_total   = 0;
        checks_passed  = 0;
        reset          = 1'b0;
        stall_e        = 1'b0;
        flush_e        = 1'b0;
        forward_a      = 2'b00;
        forward_b      = 2'b00;
        wb_result      = '0;
        mem_alu_result = '0;

        //             ctl     src  rd1           rd2           imm       fa     fb     wb        mem       exp_res       exp_wd
        vecs[0]  = '{3'b001, 1'b0, 32'd5,        32'd7,        32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'hFFFFFFFE, 32'd7};
        vecs[1]  = '{3'b001, 1'b0, 32'd5,        32'd7,        32'h0,    2'b10, 2'b00, 32'h0,    32'd7,    32'h0,        32'd7};
        vecs[2]  = '{3'b101, 1'b0, 32'h80000000, 32'd1,        32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'd1,        32'd1};
        vecs[3]  = '{3'b000, 1'b0, 32'hFFFFFFFF, 32'd1,        32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'd1};
        vecs[4]  = '{3'b010, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h00F000F0, 32'h0FF00FF0};
        vecs[5]  = '{3'b011, 1'b0, 32'hF0000000, 32'h0000000F, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'hF000000F, 32'h0000000F};
        vecs[6]  = '{3'b110, 1'b0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h55555555, 32'hFFFFFFFF};
        vecs[7]  = '{3'b100, 1'b0, 32'h12,       32'h34,       32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h34};
        vecs[8]  = '{3'b111, 1'b0, 32'h12,       32'h34,       32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h34};
        vecs[9]  = '{3'b101, 1'b0, 32'd1,        32'h80000000, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h80000000};
        vecs[10] = '{3'b000, 1'b1, 32'h20,       32'hDEAD,     32'h10,   2'b00, 2'b00, 32'h0,    32'h0,    32'h30,       32'hDEAD};
        vecs[11] = '{3'b001, 1'b0, 32'h22,       32'h99,       32'h0,    2'b00, 2'b01, 32'h11,   32'h0,    32'h11,       32'h11};
        vecs[12] = '{3'b000, 1'b0, 32'd3,        32'd4,        32'h0,    2'b11, 2'b11, 32'd200,  32'd100,  32'd7,        32'd4};
        vecs[13] = '{3'b001, 1'b0, 32'd1,        32'd2,        32'h0,    2'b01, 2'b10, 32'h50,   32'h30,   32'h20,       32'h30};

        // Reset with every decode field nonzero.
        bus.id_valid       = 1'b1;
        bus.id_alu_control = 3'b110;
        bus.id_alu_src     = 1'b1;
        bus.id_reg_write   = 1'b1;
        bus.id_mem_write   = 1'b1;
        bus.id_jump        = 1'b1;
        bus.id_branch      = 1'b1;
        bus.id_result_src  = 2'b11;
        bus.id_rd1         = 32'hFFFFFFFF;
        bus.id_rd2         = 32'h12345678;
        bus.id_imm_ext     = 32'h44;
        bus.id_pc          = 32'h200;
        bus.id_pc_plus4    = 32'h204;
        bus.id_rs1         = 5'd1;
        bus.id_rs2         = 5'd2;
        bus.id_rd          = 5'd3;
        reset = 1'b1;
        tick();
        tick();
        check("rst_valid",      32'(bus.ex_valid), 32'd0);
        check("rst_reg_write",  32'(bus.ex_reg_write), 32'd0);
        check("rst_mem_write",  32'(bus.ex_mem_write), 32'd0);
        check("rst_alu_result", bus.ex_alu_result, 32'd0);
        check("rst_zero",       32'(bus.ex_zero), 32'd1);
        check("rst_pc_src",     32'(bus.ex_pc_src), 32'd0);
        check("rst_rd",         32'(bus.ex_rd), 32'd0);
        check("rst_result_src", 32'(bus.ex_result_src), 32'd0);
        check("rst_pc_target",  bus.ex_pc_target, 32'd0);
        reset = 1'b0;
        clear_id();

        // ALU and forwarding table.
        for (int i = 0; i < NVEC; i++) begin
            bus.id_valid       = 1'b1;
            bus.id_alu_control = vecs[i].ctl;
            bus.id_alu_src     = vecs[i].src;
            bus.id_rd1         = vecs[i].rd1;
            bus.id_rd2         = vecs[i].rd2;
            bus.id_imm_ext     = vecs[i].imm;
            forward_a          = vecs[i].fa;
            forward_b          = vecs[i].fb;
            wb_result          = vecs[i].wb;
            mem_alu_result     = vecs[i].mem;
            tick();
            check($sformatf("vec%0d_result", i), bus.ex_alu_result, vecs[i].exp_res);
            check($sformatf("vec%0d_zero", i), 32'(bus.ex_zero), 32'(vecs[i].exp_res == 32'h0));
            check($sformatf("vec%0d_wdata", i), bus.ex_write_data, vecs[i].exp_wd);
        end
        forward_a = 2'b00;
        forward_b = 2'b00;
        clear_id();

        // Forwarding change without a clock edge propagates the same cycle.
        bus.id_valid = 1'b1;
        bus.id_rd1   = 32'd10;
        bus.id_rd2   = 32'd1;
        tick();
        check("fwd_before", bus.ex_alu_result, 32'd11);
        mem_alu_result = 32'd100;
        forward_a      = 2'b10;
        #1;
        check("fwd_same_cycle", bus.ex_alu_result, 32'd101);
        forward_a = 2'b00;

        // Taken beq: equal operands, target pc+imm.
        clear_id();
        bus.id_valid       = 1'b1;
        bus.id_branch      = 1'b1;
        bus.id_alu_control = 3'b001;
        bus.id_pc          = 32'h100;
        bus.id_imm_ext     = 32'h20;
        bus.id_rd1         = 32'd9;
        bus.id_rd2         = 32'd9;
        tick();
        check("br_target",  bus.ex_pc_target, 32'h120);
        check("br_pc_src",  32'(bus.ex_pc_src), 32'd1);
        bus.id_valid = 1'b0;
        tick();
        check("br_bubble_pc_src", 32'(bus.ex_pc_src), 32'd0);
        check("br_bubble_valid",  32'(bus.ex_valid), 32'd0);
        bus.id_valid = 1'b1;
        bus.id_rd2   = 32'd8;
        tick();
        check("br_not_taken", 32'(bus.ex_pc_src), 32'd0);
        bus.id_branch = 1'b0;
        bus.id_jump   = 1'b1;
        bus.id_pc     = 32'hFFFFFFF0;
        tick();
        check("jump_pc_src",      32'(bus.ex_pc_src), 32'd1);
        check("jump_target_wrap", bus.ex_pc_target, 32'h10);

        // Bubble suppresses writes even with stored controls set.
        clear_id();
        bus.id_reg_write = 1'b1;
        bus.id_mem_write = 1'b1;
        bus.id_jump      = 1'b1;
        tick();
        check("bubble_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check("bubble_mem_write", 32'(bus.ex_mem_write), 32'd0);
        check("bubble_pc_src",    32'(bus.ex_pc_src), 32'd0);

        // Stall: A held for three observations, B enters after release.
        clear_id();
        bus.id_valid    = 1'b1;
        bus.id_rd1      = 32'd1;
        bus.id_rd2      = 32'd2;
        bus.id_rd       = 5'd5;
        bus.id_pc_plus4 = 32'h44;
        tick();
        check("stall_a0_result", bus.ex_alu_result, 32'd3);
        bus.id_rd1      = 32'd10;
        bus.id_rd2      = 32'd20;
        bus.id_rd       = 5'd6;
        bus.id_pc_plus4 = 32'h88;
        stall_e = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tick();
            check($sformatf("stall_a%0d_result", k), bus.ex_alu_result, 32'd3);
            check($sformatf("stall_a%0d_rd", k), 32'(bus.ex_rd), 32'd5);
            check($sformatf("stall_a%0d_pc4", k), bus.ex_pc_plus4, 32'h44);
        end
        stall_e = 1'b0;
        tick();
        check("stall_b_result", bus.ex_alu_result, 32'd30);
        check("stall_b_rd",     32'(bus.ex_rd), 32'd6);

        // Stall and flush together: flush wins.
        clear_id();
        bus.id_valid     = 1'b1;
        bus.id_reg_write = 1'b1;
        bus.id_mem_write = 1'b1;
        bus.id_rd        = 5'd7;
        tick();
        check("sf_pre_reg_write", 32'(bus.ex_reg_write), 32'd1);
        check("sf_pre_mem_write", 32'(bus.ex_mem_write), 32'd1);
        stall_e = 1'b1;
        flush_e = 1'b1;
        tick();
        check("sf_valid",     32'(bus.ex_valid), 32'd0);
        check("sf_reg_write", 32'(bus.ex_reg_write), 32'd0);
        check("sf_mem_write", 32'(bus.ex_mem_write), 32'd0);
        check("sf_rd",        32'(bus.ex_rd), 32'd0);

        // Back-to-back flushes keep loading bubbles.
        stall_e = 1'b0;
        tick();
        check("flush2_valid", 32'(bus.ex_valid), 32'd0);
        check("flush2_rd",    32'(bus.ex_rd), 32'd0);
        flush_e = 1'b0;
        tick();
        check("post_flush_valid", 32'(bus.ex_valid), 32'd1);
        check("post_flush_rd",    32'(bus.ex_rd), 32'd7);

        // Reset during a stall clears the register.
        stall_e = 1'b1;
        reset   = 1'b1;
        tick();
        check("rst_stall_valid", 32'(bus.ex_valid), 32'd0);
        check("rst_stall_rd",    32'(bus.ex_rd), 32'd0);
        reset   = 1'b0;
        stall_e = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage pipelined RISC-V core. Holds the ID/EX pipeline register and consumes the 3-bit ALU control code produced by the ALU decoder in decode. Performs operand forwarding, the ALU operation, branch-target generation and branch resolution. Results feed the EX/MEM register and the hazard unit.

## Interface
- No parameters; data width is fixed at 32, register addresses at 5.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears the ID/EX register
- stall_e  in  1  hold ID/EX contents (load-use stall from hazard unit)
- flush_e  in  1  load a bubble into ID/EX (taken branch/jump, load-use)
- id_valid  in  1  decode slot holds a real instruction
- id_alu_control  in  3  ALU code from ALU decoder
- id_alu_src  in  1  1: operand B = immediate, 0: forwarded rs2
- id_reg_write, id_mem_write, id_jump, id_branch  in  1 each  decode controls
- id_result_src  in  2  writeback select, passed through
- id_rd1, id_rd2, id_imm_ext, id_pc, id_pc_plus4  in  32 each  decode data
- id_rs1, id_rs2, id_rd  in  5 each  register addresses
- forward_a, forward_b  in  2 each  00 register file, 01 wb_result, 10 mem_alu_result, 11 same as 00
- wb_result, mem_alu_result  in  32 each  forwarding sources
- ex_valid  out  1  EX slot holds a real instruction
- ex_reg_write, ex_mem_write  out  1 each  registered controls ANDed with ex_valid
- ex_result_src  out  2; ex_rd, ex_rs1, ex_rs2  out  5 each  registered pass-through
- ex_alu_result, ex_write_data, ex_pc_target, ex_pc_plus4  out  32 each
- ex_zero  out  1  ex_alu_result == 0
- ex_pc_src  out  1  ex_valid & (ex_jump | (ex_branch & ex_zero))

## Operation
- ID/EX register update priority per edge: reset > flush_e > stall_e > load.
- reset or flush_e: every stored field cleared to 0 (valid, controls, data, addresses, alu_control).
- stall_e (no flush): all fields hold.
- Otherwise: all id_* inputs captured; valid <= id_valid.
- Operand A = forward_a mux over stored rd1 / wb_result / mem_alu_result.
- ex_write_data = forward_b mux over stored rd2 / wb_result / mem_alu_result.
- Operand B = stored imm_ext if alu_src else ex_write_data.
- ALU codes: 000 A+B; 001 A-B; 010 A&B; 011 A|B; 101 signed A<B ? 1 : 0; 110 A^B; 100 and 111 result 0.
- Add/sub wrap modulo 2^32; no overflow flag. SLT compares as two's complement (0x80000000 < 0x00000001).
- ex_pc_target = stored pc + stored imm_ext, modulo 2^32.
- Branch resolution covers beq only (branch & zero); jump forces ex_pc_src.
- Bubble (valid=0) never asserts ex_reg_write, ex_mem_write or ex_pc_src, regardless of stored controls.

## Timing
- Reset values: ex_valid, ex_reg_write, ex_mem_write, ex_pc_src 0; ex_result_src, ex_rd, ex_rs1, ex_rs2 0.
- After reset, data outputs are 0 except ex_zero = 1, with forwarding selects at 00.
- Latency: id_* sampled at edge N appear in EX outputs after edge N, combinationally.
- EX outputs are combinational from the register plus forwarding inputs. Forwarding changes within a cycle propagate the same cycle.
- flush_e and stall_e asserted together: flush wins, bubble inserted.
- reset mid-stall: register cleared on the reset edge; stall ignored.
- Stall held for k cycles: outputs stable for k+1 cycles, given constant forwarding inputs.
- Back-to-back flushes: each edge loads another bubble.

## Test plan
- Reset with all id_* nonzero -> ex_valid=0, ex_reg_write=0, ex_alu_result=0, ex_zero=1, ex_pc_src=0.
- Load rd1=5, rd2=7, alu_control=001, alu_src=0, forwards 00 -> next cycle ex_alu_result=0xFFFFFFFE, ex_zero=0.
- Same instruction with forward_a=10, mem_alu_result=7 -> ex_alu_result=0, ex_zero=1. Repeat with alu_control=101, rd1=0x80000000, rd2=1 -> result 1.
- Branch: pc=0x100, imm=0x20, rd1=rd2=9, code 001, branch=1, valid=1 -> ex_pc_target=0x120, ex_pc_src=1. Same cycle with valid=0 -> ex_pc_src=0.
- Load instruction A, then stall_e=1 for 2 cycles while presenting B -> A held 3 cycles; B appears on the edge after stall_e drops.
- stall_e=1 and flush_e=1 on same edge with reg_write=1, mem_write=1 loaded -> ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_rd=0.
